sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_pkg.sv | 17 +
 rtl/sdram_ctrl_if.sv | 27 ++
 rtl/sdram_wdog.sv | 28 ++
 rtl/sdram_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types for the two-client SDRAM arbiter and its watchdog.
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef logic client_idx_t;

    // Counter width able to hold the watchdog limit itself.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sdram_ctrl_if.sv
// Request/response bundle between an SDRAM client and the controller side.
interface sdram_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    localparam int WORD_LEN = DATA_WIDTH / 8;

    logic [WORD_LEN-1:0]   wr;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  rdy;
    logic                  rvalid;
    logic                  wvalid;
    logic                  error;
    logic [DATA_WIDTH-1:0] read_data;

    modport man (
        output wr, rd, addr, write_data,
        input  rdy, rvalid, wvalid, error, read_data
    );

    modport sub (
        input  wr, rd, addr, write_data,
        output rdy, rvalid, wvalid, error, read_data
    );
endinterface

// File: rtl/sdram_wdog.sv
// WAIT-phase watchdog: counts enabled cycles and pulses o_expire when the
// count reaches i_limit; a limit of zero never expires.
module sdram_wdog #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_enable,
    input  logic [CW-1:0] i_limit,
    output logic          o_expire
);
    logic [CW-1:0] r_count;
    logic          w_active;

    assign w_active = i_enable && (i_limit != '0);
    assign o_expire = w_active && (r_count == i_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_active && (r_count != i_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Two-client round-robin arbiter in front of a single SDRAM controller port,
// with one outstanding transaction and a WAIT-phase timeout.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic      clk,
    input  logic      rst,
    sdram_ctrl_if.sub c0,
    sdram_ctrl_if.sub c1,
    sdram_ctrl_if.man m
);
    localparam int WORD_LEN = DATA_WIDTH / 8;
    localparam int CW       = cnt_width(TIMEOUT_CYCLES);

    arb_state_t  r_state;
    client_idx_t r_grant;
    client_idx_t r_ptr;

    logic                  w_req0, w_req1, w_gnt_req;
    logic                  w_in_issue, w_in_wait;
    logic                  w_done, w_expire, w_err;
    logic                  w_sel0, w_sel1;
    logic                  w_gnt_rd;
    logic [WORD_LEN-1:0]   w_gnt_wr;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [DATA_WIDTH-1:0] w_gnt_wdata;

    assign w_req0     = c0.rd | (|c0.wr);
    assign w_req1     = c1.rd | (|c1.wr);
    assign w_gnt_req  = r_grant ? w_req1 : w_req0;
    assign w_in_issue = (r_state == ISSUE);
    assign w_in_wait  = (r_state == WAIT);
    assign w_sel0     = (r_grant == 1'b0);
    assign w_sel1     = (r_grant == 1'b1);

    // A genuine completion in the expiry cycle wins over the timeout error.
    assign w_done = m.rvalid | m.wvalid | m.error;
    assign w_err  = w_done ? m.error : w_expire;

    sdram_wdog #(.CW(CW)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_in_wait),
        .i_enable (w_in_wait),
        .i_limit  (CW'(TIMEOUT_CYCLES)),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant <= (w_req0 & w_req1) ? r_ptr : w_req1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!w_gnt_req) begin
                        r_state <= IDLE;
                    end else if (m.rdy) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_done | w_expire) begin
                        r_state <= IDLE;
                        r_ptr   <= ~r_grant;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_gnt_rd    = r_grant ? c1.rd : c0.rd;
    assign w_gnt_wr    = r_grant ? c1.wr : c0.wr;
    assign w_gnt_addr  = r_grant ? c1.addr : c0.addr;
    assign w_gnt_wdata = r_grant ? c1.write_data : c0.write_data;

    // Commands reach the controller only while issuing.
    assign m.rd         = w_in_issue & w_gnt_rd;
    assign m.wr         = w_in_issue ? w_gnt_wr : '0;
    assign m.addr       = w_gnt_addr;
    assign m.write_data = w_gnt_wdata;

    assign c0.rdy       = w_in_issue & w_sel0 & m.rdy;
    assign c0.rvalid    = w_in_wait & w_sel0 & m.rvalid;
    assign c0.wvalid    = w_in_wait & w_sel0 & m.wvalid;
    assign c0.error     = w_in_wait & w_sel0 & w_err;
    assign c0.read_data = m.read_data;

    assign c1.rdy       = w_in_issue & w_sel1 & m.rdy;
    assign c1.rvalid    = w_in_wait & w_sel1 & m.rvalid;
    assign c1.wvalid    = w_in_wait & w_sel1 & m.wvalid;
    assign c1.error     = w_in_wait & w_sel1 & w_err;
    assign c1.read_data = m.read_data;
endmodule
